axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 Parameters SHALL be:
- AXI_ID_WIDTH, 6, slave-side ID width.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width.
REQ-002 Clock and reset SHALL be:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  reset, asynchronous and active-high.
REQ-003 Each slave port sN, N in {0,1}, SHALL carry the following signals; directions are as seen by this module:
- sN_axi_awid/awaddr/awlen/awsize/awburst/awcache  in  ID/ADDR/4/3/2/4  write-address fields.
- sN_axi_awvalid  in  1;  sN_axi_awready  out  1.
- sN_axi_wid  in  ID;  sN_axi_wdata  in  DATA;  sN_axi_wstrb  in  DATA/8;  sN_axi_wlast  in  1.
- sN_axi_wvalid  in  1;  sN_axi_wready  out  1.
- sN_axi_bvalid  out  1;  sN_axi_bready  in  1.
REQ-004 The master port SHALL carry the following signals:
- m_axi_awid  out  ID+1;  m_axi_aw* (other address fields)  out  same widths as slave.
- m_axi_awvalid  out  1;  m_axi_awready  in  1.
- m_axi_wid  out  ID+1;  m_axi_wdata/wstrb/wlast/wvalid  out;  m_axi_wready  in  1.
- m_axi_bid  in  ID+1;  m_axi_bvalid  in  1;  m_axi_bready  out  1.
REQ-005 Status outputs SHALL be:
- sts_burst0, sts_burst1  out  32 each  completed-burst counters.
- sts_grant  out  2  one-hot current owner; 00 when idle.

Function
REQ-006 The arbiter SHALL share one AXI3 write master between two burst writers, switching only at burst granularity.
REQ-007 The FSM SHALL have states IDLE and BURST, plus flags aw_done and w_done.
REQ-008 In IDLE, a request from port N is sN_axi_awvalid=1; the grant SHALL be registered, and the FSM SHALL enter BURST on the next cycle.
REQ-009 Priority SHALL be round-robin. With both requesting, the port not granted last wins. After reset, port 0 has priority.
REQ-010 In BURST, AW and W channels of the owner SHALL be combinationally forwarded: valid, data and fields pass down, and ready passes back. The other slave's awready and wready SHALL be 0.
REQ-011 m_axi_awvalid SHALL be 0 once aw_done is set. aw_done SHALL be set on m_axi_awvalid & m_axi_awready.
REQ-012 w_done SHALL be set on m_axi_wvalid & m_axi_wready & m_axi_wlast. m_axi_wvalid SHALL be 0 once w_done is set.
REQ-013 AW and W handshakes MAY complete in either order or in the same cycle.
REQ-014 BURST SHALL return to IDLE in the cycle after both flags are set, or are being set. Flags SHALL clear on that exit.
REQ-015 Minimum gap between consecutive bursts SHALL be 1 idle cycle.
REQ-016 m_axi_awid and m_axi_wid SHALL equal {N, sN id}.
REQ-017 B routing SHALL be independent of the grant:
- sN_axi_bvalid = m_axi_bvalid & (m_axi_bid MSB == N).
- m_axi_bready = bready of the port selected by m_axi_bid MSB.
REQ-018 In IDLE, all master valids SHALL be 0 and all slave readies SHALL be 0.
REQ-019 sts_burstN SHALL increment by 1 in the cycle BURST exits with owner N. It SHALL wrap from 2^32-1 to 0.
REQ-020 A slave that deasserts awvalid before its grant registers SHALL still be granted. The FSM waits in BURST and does not drop the burst.

Reset
REQ-021 While areset=1, the following SHALL hold asynchronously:
- State = IDLE; aw_done = w_done = 0.
- Round-robin pointer selects port 0.
- sts_grant = 00; sts_burst0 = sts_burst1 = 0.
- All valids and readies are 0.
REQ-022 Reset asserted mid-burst SHALL abandon the burst with no further handshakes. After release, the FSM restarts from IDLE.

Structure
REQ-023 A shared package SHALL hold:
- The state enum {IDLE, BURST}.
- The constant NUM_PORTS = 2.
- The AW-field bundle widths derived from the parameters.
REQ-024 One sub-module SHALL exist: axi_rr_arbiter2 (2-way round-robin grant with registered last-winner pointer). All muxing stays in the top level.

Verification
REQ-025 Single burst: s0 issues 16 beats at awaddr 0x1000_0000, m ready always 1. Required response:
- m_axi_awaddr = 0x1000_0000 and m_axi_awid = {0, s0 id}.
- 16 W beats pass through with wlast on beat 16.
- sts_burst0 = 1.
REQ-026 Contention: s0 and s1 request in the same cycle from reset, each sending 3 bursts. Grant order SHALL be 0,1,0,1,0,1, and sts_burst0 = sts_burst1 = 3.
REQ-027 W before AW: hold m_axi_awready = 0 for 20 cycles while W is accepted. Required response:
- FSM stays in BURST until AW completes.
- wvalid = 0 after wlast.
- s1 is not granted meanwhile.
REQ-028 B routing: drive m_axi_bvalid with bid MSB=1 while s0 owns the bus. Required response: s1_axi_bvalid = 1, s0_axi_bvalid = 0, and m_axi_bready follows s1_axi_bready.
REQ-029 Reset after the 7th W beat: assert areset. Required response:
- All valids drop in the same cycle.
- After release, s1 requesting alone is granted, and its burst completes with sts_burst1 = 1.

Source files
------------

// File: rtl/axi_write_arbiter_pkg.sv
// rtl/axi_write_arbiter_pkg.sv - shared types and widths for the two-port AXI3 write arbiter
package axi_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NUM_PORTS  = 2;

  localparam int AW_LEN_W   = 4;
  localparam int AW_SIZE_W  = 3;
  localparam int AW_BURST_W = 2;
  localparam int AW_CACHE_W = 4;
  localparam int AW_FIXED_W = AW_LEN_W + AW_SIZE_W + AW_BURST_W + AW_CACHE_W;

  // Packed AW bundle is {id, addr, len, size, burst, cache}.
  function automatic int aw_bundle_w(input int id_w, input int addr_w);
    return id_w + addr_w + AW_FIXED_W;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter2.sv
// rtl/axi_rr_arbiter2.sv - 2-way round-robin grant with registered last-winner pointer
module axi_rr_arbiter2
  import axi_write_arbiter_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_take,
  output logic [NUM_PORTS-1:0] o_grant
);

  // Reset value 1 means port 1 "won last", so port 0 goes first.
  logic r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_take && (|i_req)) begin
      r_last <= o_grant[1];
    end
  end

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - burst-granular arbiter sharing one AXI3 write master between two writers
module axi_write_arbiter
  import axi_write_arbiter_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
)
(
  input  logic                        aclk,
  input  logic                        areset,

  input  logic [AXI_ID_WIDTH-1:0]     s0_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic [3:0]                  s0_axi_awlen,
  input  logic [2:0]                  s0_axi_awsize,
  input  logic [1:0]                  s0_axi_awburst,
  input  logic [3:0]                  s0_axi_awcache,
  input  logic                        s0_axi_awvalid,
  output logic                        s0_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]     s0_axi_wid,
  input  logic [AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                        s0_axi_wlast,
  input  logic                        s0_axi_wvalid,
  output logic                        s0_axi_wready,
  output logic                        s0_axi_bvalid,
  input  logic                        s0_axi_bready,

  input  logic [AXI_ID_WIDTH-1:0]     s1_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic [3:0]                  s1_axi_awlen,
  input  logic [2:0]                  s1_axi_awsize,
  input  logic [1:0]                  s1_axi_awburst,
  input  logic [3:0]                  s1_axi_awcache,
  input  logic                        s1_axi_awvalid,
  output logic                        s1_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]     s1_axi_wid,
  input  logic [AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                        s1_axi_wlast,
  input  logic                        s1_axi_wvalid,
  output logic                        s1_axi_wready,
  output logic                        s1_axi_bvalid,
  input  logic                        s1_axi_bready,

  output logic [AXI_ID_WIDTH:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [3:0]                  m_axi_awcache,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ID_WIDTH:0]       m_axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH:0]       m_axi_bid,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,

  output logic [31:0]                 sts_burst0,
  output logic [31:0]                 sts_burst1,
  output logic [1:0]                  sts_grant
);

  localparam int AW_W = aw_bundle_w(AXI_ID_WIDTH, AXI_ADDR_WIDTH);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_aw_done;
  logic       r_w_done;
  logic       r_owner;
  logic [NUM_PORTS-1:0] r_grant;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_arb_grant;
  logic                 w_idle_take;
  logic [AW_W-1:0]      w_s0_aw;
  logic [AW_W-1:0]      w_s1_aw;
  logic [AW_W-1:0]      w_aw_sel;
  logic [AXI_ID_WIDTH-1:0] w_sel_awid;
  logic w_sel_awvalid;
  logic w_sel_wvalid;
  logic w_in_burst;
  logic w_aw_rdy;
  logic w_w_rdy;
  logic w_aw_hs;
  logic w_wlast_hs;
  logic w_exit;
  logic w_bid_port;
  logic w_bid_unused;

  assign w_req       = {s1_axi_awvalid, s0_axi_awvalid};
  assign w_idle_take = (r_state == IDLE) && (|w_req);

  axi_rr_arbiter2 u_rr (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_req   (w_req),
    .i_take  (w_idle_take),
    .o_grant (w_arb_grant)
  );

  assign w_s0_aw  = {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awsize, s0_axi_awburst, s0_axi_awcache};
  assign w_s1_aw  = {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awsize, s1_axi_awburst, s1_axi_awcache};
  assign w_aw_sel = r_owner ? w_s1_aw : w_s0_aw;
  assign {w_sel_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache} = w_aw_sel;
  assign m_axi_awid = {r_owner, w_sel_awid};

  assign m_axi_wid   = {r_owner, (r_owner ? s1_axi_wid : s0_axi_wid)};
  assign m_axi_wdata = r_owner ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb = r_owner ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast = r_owner ? s1_axi_wlast : s0_axi_wlast;

  assign w_sel_awvalid = r_owner ? s1_axi_awvalid : s0_axi_awvalid;
  assign w_sel_wvalid  = r_owner ? s1_axi_wvalid  : s0_axi_wvalid;

  // Each channel closes independently; its valid/ready stay low once its flag is set.
  assign w_in_burst    = (r_state == BURST);
  assign m_axi_awvalid = w_in_burst & ~r_aw_done & w_sel_awvalid;
  assign m_axi_wvalid  = w_in_burst & ~r_w_done & w_sel_wvalid;
  assign w_aw_rdy      = w_in_burst & ~r_aw_done & m_axi_awready;
  assign w_w_rdy       = w_in_burst & ~r_w_done & m_axi_wready;

  assign s0_axi_awready = w_aw_rdy & ~r_owner;
  assign s1_axi_awready = w_aw_rdy &  r_owner;
  assign s0_axi_wready  = w_w_rdy  & ~r_owner;
  assign s1_axi_wready  = w_w_rdy  &  r_owner;

  assign w_aw_hs    = m_axi_awvalid & m_axi_awready;
  assign w_wlast_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign w_exit     = w_in_burst & (r_aw_done | w_aw_hs) & (r_w_done | w_wlast_hs);

  // B responses route on the ID's port bit, not on the current owner.
  assign w_bid_port    = m_axi_bid[AXI_ID_WIDTH];
  assign w_bid_unused  = ^m_axi_bid[AXI_ID_WIDTH-1:0];
  assign s0_axi_bvalid = ~areset & m_axi_bvalid & ~w_bid_port;
  assign s1_axi_bvalid = ~areset & m_axi_bvalid &  w_bid_port;
  assign m_axi_bready  = ~areset & (w_bid_port ? s1_axi_bready : s0_axi_bready);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (|w_req) w_state_nxt = BURST;
      BURST: if (w_exit) w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_exit) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_in_burst) begin
      if (w_aw_hs)    r_aw_done <= 1'b1;
      if (w_wlast_hs) r_w_done  <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_owner <= 1'b0;
      r_grant <= '0;
    end else if (w_idle_take) begin
      r_owner <= w_arb_grant[1];
      r_grant <= w_arb_grant;
    end else if (w_exit) begin
      r_grant <= '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sts_burst0 <= '0;
      sts_burst1 <= '0;
    end else if (w_exit) begin
      if (r_owner) sts_burst1 <= sts_burst1 + 32'd1;
      else         sts_burst0 <= sts_burst0 + 32'd1;
    end
  end

  assign sts_grant = r_grant;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - directed self-checking bench for axi_write_arbiter
module tb_axi_write_arbiter;

  localparam int ID = 6;
  localparam int AW = 32;
  localparam int DW = 64;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [ID-1:0] s0_awid, s1_awid, s0_wid, s1_wid;
  logic [AW-1:0] s0_awaddr, s1_awaddr;
  logic [3:0] s0_awlen, s1_awlen, s0_awcache, s1_awcache;
  logic [2:0] s0_awsize, s1_awsize;
  logic [1:0] s0_awburst, s1_awburst;
  logic s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic [DW/8-1:0] s0_wstrb, s1_wstrb;
  logic s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic s0_bvalid, s1_bvalid, s0_bready, s1_bready;

  logic [ID:0] m_awid, m_wid, m_bid;
  logic [AW-1:0] m_awaddr;
  logic [3:0] m_awlen, m_awcache;
  logic [2:0] m_awsize;
  logic [1:0] m_awburst;
  logic m_awvalid, m_awready;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] sts_burst0, sts_burst1;
  logic [1:0] sts_grant;

  int n_pass  = 0;
  int n_total = 0;

  axi_write_arbiter #(.AXI_ID_WIDTH(ID), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .s0_axi_awid(s0_awid), .s0_axi_awaddr(s0_awaddr), .s0_axi_awlen(s0_awlen),
    .s0_axi_awsize(s0_awsize), .s0_axi_awburst(s0_awburst), .s0_axi_awcache(s0_awcache),
    .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(s0_awready),
    .s0_axi_wid(s0_wid), .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wlast(s0_wlast),
    .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready),
    .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s0_bready),
    .s1_axi_awid(s1_awid), .s1_axi_awaddr(s1_awaddr), .s1_axi_awlen(s1_awlen),
    .s1_axi_awsize(s1_awsize), .s1_axi_awburst(s1_awburst), .s1_axi_awcache(s1_awcache),
    .s1_axi_awvalid(s1_awvalid), .s1_axi_awready(s1_awready),
    .s1_axi_wid(s1_wid), .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wlast(s1_wlast),
    .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(s1_wready),
    .s1_axi_bvalid(s1_bvalid), .s1_axi_bready(s1_bready),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awcache(m_awcache),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wid(m_wid), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .sts_burst0(sts_burst0), .sts_burst1(sts_burst1), .sts_grant(sts_grant)
  );

  task automatic idle_inputs();
    s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd3; s0_awburst = 2'b01; s0_awcache = '0;
    s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd3; s1_awburst = 2'b01; s1_awcache = '0;
    s0_awvalid = 0; s1_awvalid = 0;
    s0_wid = '0; s0_wdata = '0; s0_wstrb = '1; s0_wlast = 0; s0_wvalid = 0;
    s1_wid = '0; s1_wdata = '0; s1_wstrb = '1; s1_wlast = 0; s1_wvalid = 0;
    s0_bready = 0; s1_bready = 0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bvalid = 0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    idle_inputs();
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset = 1'b1;
    s0_awvalid = 1; s0_wvalid = 1; m_awready = 1; m_wready = 1;
    s0_bready = 1; m_bvalid = 1; m_bid = '0;
    @(negedge aclk); @(negedge aclk); #1;
    n_total++; if (sts_grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", sts_grant); else n_pass++;
    n_total++; if (sts_burst0 !== 32'd0) $display("FAIL reset_burst0: got %0d want 0", sts_burst0); else n_pass++;
    n_total++; if (sts_burst1 !== 32'd0) $display("FAIL reset_burst1: got %0d want 0", sts_burst1); else n_pass++;
    n_total++; if (m_awvalid !== 1'b0) $display("FAIL reset_awvalid: got %b want 0", m_awvalid); else n_pass++;
    n_total++; if (m_wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b want 0", m_wvalid); else n_pass++;
    n_total++; if ({s0_awready, s0_wready} !== 2'b00) $display("FAIL reset_s0_ready: got %b want 00", {s0_awready, s0_wready}); else n_pass++;
    n_total++; if (s0_bvalid !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", s0_bvalid); else n_pass++;
    n_total++; if (m_bready !== 1'b0) $display("FAIL reset_bready: got %b want 0", m_bready); else n_pass++;
    idle_inputs();
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_single_burst();
    int n_beats;
    logic [DW-1:0] exp_data;
    n_beats = 0;
    @(negedge aclk);
    s0_awid = 6'h15; s0_wid = 6'h15; s0_awaddr = 32'h1000_0000; s0_awlen = 4'hF;
    s0_awvalid = 1; m_awready = 1; m_wready = 1;
    #1;
    n_total++; if ({s0_awready, m_awvalid} !== 2'b00) $display("FAIL idle_no_handshake: got %b want 00", {s0_awready, m_awvalid}); else n_pass++;
    for (int b = 0; b < 16; b++) begin
      @(negedge aclk);
      exp_data = 64'hD0D0_0000_0000_0000 | 64'(b);
      s0_wvalid = 1; s0_wdata = exp_data; s0_wlast = (b == 15);
      if (b == 2) s0_awvalid = 0;
      #1;
      if (b == 0) begin
        n_total++; if (sts_grant !== 2'b01) $display("FAIL single_grant: got %b want 01", sts_grant); else n_pass++;
        n_total++; if (m_awvalid !== 1'b1) $display("FAIL single_awvalid: got %b want 1", m_awvalid); else n_pass++;
        n_total++; if (m_awaddr !== 32'h1000_0000) $display("FAIL single_awaddr: got %h want 10000000", m_awaddr); else n_pass++;
        n_total++; if (m_awid !== 7'h15) $display("FAIL single_awid: got %h want 15", m_awid); else n_pass++;
        n_total++; if (m_wid !== 7'h15) $display("FAIL single_wid: got %h want 15", m_wid); else n_pass++;
        n_total++; if (m_awlen !== 4'hF) $display("FAIL single_awlen: got %h want f", m_awlen); else n_pass++;
        n_total++; if (s1_awready !== 1'b0) $display("FAIL single_s1_awready: got %b want 0", s1_awready); else n_pass++;
      end
      if (b == 1) begin
        n_total++; if (m_awvalid !== 1'b0) $display("FAIL single_aw_done_gate: got %b want 0", m_awvalid); else n_pass++;
      end
      if (m_wvalid && m_wready && s0_wready && (m_wdata === exp_data) && (m_wlast === (b == 15))) n_beats++;
    end
    @(negedge aclk);
    s0_wvalid = 0; s0_wlast = 0;
    #1;
    n_total++; if (n_beats !== 16) $display("FAIL single_beats: got %0d want 16", n_beats); else n_pass++;
    n_total++; if (sts_burst0 !== 32'd1) $display("FAIL single_count: got %0d want 1", sts_burst0); else n_pass++;
    n_total++; if (sts_grant !== 2'b00) $display("FAIL single_exit_grant: got %b want 00", sts_grant); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_contention();
    int ng;
    int last_cyc;
    logic [1:0] exp_g;
    logic [ID:0] exp_id;
    ng = 0; last_cyc = -1;
    do_reset();
    s0_awid = 6'h01; s0_wid = 6'h01; s1_awid = 6'h02; s1_wid = 6'h02;
    s0_awvalid = 1; s0_wvalid = 1; s0_wlast = 1;
    s1_awvalid = 1; s1_wvalid = 1; s1_wlast = 1;
    m_awready = 1; m_wready = 1;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      #1;
      if (sts_grant !== 2'b00) begin
        exp_g  = (ng % 2 == 0) ? 2'b01 : 2'b10;
        exp_id = (ng % 2 == 0) ? 7'h01 : 7'h42;
        n_total++; if (sts_grant !== exp_g) $display("FAIL rr_grant_%0d: got %b want %b", ng, sts_grant, exp_g); else n_pass++;
        n_total++; if (m_awid !== exp_id) $display("FAIL rr_awid_%0d: got %h want %h", ng, m_awid, exp_id); else n_pass++;
        ng++;
        if (ng == 6) last_cyc = cyc;
      end
      @(negedge aclk);
    end
    s0_awvalid = 0; s0_wvalid = 0; s1_awvalid = 0; s1_wvalid = 0;
    @(negedge aclk); #1;
    n_total++; if (ng !== 6) $display("FAIL rr_grant_count: got %0d want 6", ng); else n_pass++;
    n_total++; if (last_cyc !== 11) $display("FAIL rr_gap: got cycle %0d want 11", last_cyc); else n_pass++;
    n_total++; if (sts_burst0 !== 32'd3) $display("FAIL rr_burst0: got %0d want 3", sts_burst0); else n_pass++;
    n_total++; if (sts_burst1 !== 32'd3) $display("FAIL rr_burst1: got %0d want 3", sts_burst1); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_w_before_aw();
    int bad_grant, s1_leak, beats, w_leak;
    bad_grant = 0; s1_leak = 0; beats = 0; w_leak = 0;
    @(negedge aclk);
    s0_awid = 6'h0A; s0_wid = 6'h0A; s0_awlen = 4'd3; s0_awvalid = 1;
    s1_awid = 6'h0B; s1_awvalid = 1;
    m_awready = 0; m_wready = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge aclk);
      s0_wvalid = 1; s0_wdata = 64'hBEEF_0000 + 64'(cyc); s0_wlast = (cyc == 3);
      #1;
      if (sts_grant !== 2'b01 || m_awvalid !== 1'b1) bad_grant++;
      if (s1_awready || s1_wready) s1_leak++;
      if (cyc < 4 && m_wvalid && s0_wready) beats++;
      if (cyc >= 4 && (m_wvalid || s0_wready)) w_leak++;
    end
    n_total++; if (bad_grant !== 0) $display("FAIL wfirst_hold_burst: got %0d bad cycles want 0", bad_grant); else n_pass++;
    n_total++; if (s1_leak !== 0) $display("FAIL wfirst_s1_blocked: got %0d bad cycles want 0", s1_leak); else n_pass++;
    n_total++; if (beats !== 4) $display("FAIL wfirst_beats: got %0d want 4", beats); else n_pass++;
    n_total++; if (w_leak !== 0) $display("FAIL wfirst_wvalid_after_last: got %0d bad cycles want 0", w_leak); else n_pass++;
    @(negedge aclk);
    m_awready = 1; s0_wvalid = 0; s0_wlast = 0;
    #1;
    n_total++; if (s0_awready !== 1'b1) $display("FAIL wfirst_awready: got %b want 1", s0_awready); else n_pass++;
    n_total++; if (m_awid !== 7'h0A) $display("FAIL wfirst_awid: got %h want 0a", m_awid); else n_pass++;
    @(negedge aclk);
    s0_awvalid = 0;
    #1;
    n_total++; if (sts_burst0 !== 32'd4) $display("FAIL wfirst_count: got %0d want 4", sts_burst0); else n_pass++;
    n_total++; if (sts_grant !== 2'b00) $display("FAIL wfirst_exit: got %b want 00", sts_grant); else n_pass++;
    @(negedge aclk); #1;
    n_total++; if (sts_grant !== 2'b10) $display("FAIL wfirst_next_s1: got %b want 10", sts_grant); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_b_routing();
    do_reset();
    s0_awvalid = 1; m_awready = 0;
    @(negedge aclk);
    m_bvalid = 1; m_bid = 7'h43; s1_bready = 1; s0_bready = 0;
    #1;
    n_total++; if (sts_grant !== 2'b01) $display("FAIL b_owner: got %b want 01", sts_grant); else n_pass++;
    n_total++; if ({s1_bvalid, s0_bvalid} !== 2'b10) $display("FAIL b_route_s1: got %b want 10", {s1_bvalid, s0_bvalid}); else n_pass++;
    n_total++; if (m_bready !== 1'b1) $display("FAIL b_ready_s1_hi: got %b want 1", m_bready); else n_pass++;
    s1_bready = 0; s0_bready = 1;
    #1;
    n_total++; if (m_bready !== 1'b0) $display("FAIL b_ready_s1_lo: got %b want 0", m_bready); else n_pass++;
    m_bid = 7'h03;
    #1;
    n_total++; if ({s1_bvalid, s0_bvalid} !== 2'b01) $display("FAIL b_route_s0: got %b want 01", {s1_bvalid, s0_bvalid}); else n_pass++;
    n_total++; if (m_bready !== 1'b1) $display("FAIL b_ready_s0: got %b want 1", m_bready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s0_awid = 6'h05; s0_wid = 6'h05; s0_awlen = 4'hF; s0_awvalid = 1;
    m_awready = 1; m_wready = 1;
    for (int b = 0; b < 7; b++) begin
      @(negedge aclk);
      s0_wvalid = 1; s0_wdata = 64'(b); s0_wlast = 0;
    end
    @(negedge aclk);
    s0_wdata = 64'd7;
    #1;
    n_total++; if (m_wvalid !== 1'b1) $display("FAIL midrst_pre_wvalid: got %b want 1", m_wvalid); else n_pass++;
    areset = 1'b1;
    #1;
    n_total++; if ({m_awvalid, m_wvalid} !== 2'b00) $display("FAIL midrst_valids: got %b want 00", {m_awvalid, m_wvalid}); else n_pass++;
    n_total++; if ({s0_awready, s0_wready} !== 2'b00) $display("FAIL midrst_readies: got %b want 00", {s0_awready, s0_wready}); else n_pass++;
    n_total++; if (sts_grant !== 2'b00) $display("FAIL midrst_grant: got %b want 00", sts_grant); else n_pass++;
    s0_awvalid = 0; s0_wvalid = 0;
    s1_awid = 6'h21; s1_wid = 6'h21; s1_awlen = 4'd1; s1_awvalid = 1;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    s1_wvalid = 1; s1_wdata = 64'h11; s1_wlast = 0;
    #1;
    n_total++; if (sts_grant !== 2'b10) $display("FAIL midrst_s1_grant: got %b want 10", sts_grant); else n_pass++;
    n_total++; if (m_awid !== 7'h61) $display("FAIL midrst_s1_awid: got %h want 61", m_awid); else n_pass++;
    @(negedge aclk);
    s1_wdata = 64'h22; s1_wlast = 1;
    @(negedge aclk);
    s1_wvalid = 0; s1_wlast = 0; s1_awvalid = 0;
    #1;
    n_total++; if (sts_burst1 !== 32'd1) $display("FAIL midrst_burst1: got %0d want 1", sts_burst1); else n_pass++;
    n_total++; if (sts_burst0 !== 32'd0) $display("FAIL midrst_burst0: got %0d want 0", sts_burst0); else n_pass++;
    n_total++; if (sts_grant !== 2'b00) $display("FAIL midrst_exit: got %b want 00", sts_grant); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    areset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_burst();
    test_contention();
    test_w_before_aw();
    test_b_routing();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
